// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width/depth, registered status flags,
// programmable almost-full/almost-empty thresholds, sticky error flags,
// synchronous flush and a selectable FWFT or registered-read output.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int unsigned     DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL    = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic              ovf_evt;
    logic              unf_evt;
    logic [ADDR_W:0]   level_next;

    // Accept decisions and next occupancy, all from the pre-edge status.
    // A write into a full FIFO is accepted only when a read frees the head slot.
    always_comb begin
        rd_acc     = rd & ~empty & ~clr;
        wr_acc     = wr & (~full | rd_acc) & ~clr;
        ovf_evt    = wr & full & ~rd_acc & ~clr;
        unf_evt    = rd & empty & ~clr;
        level_next = level;
        if (clr) begin
            level_next = '0;
        end else if (wr_acc && !rd_acc) begin
            level_next = level + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            level_next = level - 1'b1;
        end
    end

    // Read/write pointers; natural ADDR_W-bit wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Registered occupancy and status flags derived from the post-edge level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            level        <= level_next;
            full         <= (level_next == DEPTH_LVL);
            empty        <= (level_next == '0);
            almost_full  <= (level_next >= AF_LVL);
            almost_empty <= (level_next <= AE_LVL);
        end
    end

    // Sticky error flags; a same-cycle error event wins over err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (unf_evt)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible combinationally whenever the FIFO is non-empty.
            always_comb begin
                data_out = mem[rd_ptr];
            end
        end else begin : g_regread
            // Registered read: capture head on an accepted read, hold otherwise.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_out <= '0;
                end else if (rd_acc) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule
